// File: rtl/cordic_phase_arbiter.sv
// rtl/cordic_phase_arbiter.sv - round-robin sharing of one pipelined atan2 CORDIC among phase channels
module cordic_phase_arbiter #(
    parameter int NUM_CH      = 4,
    parameter int WIDTH       = 16,
    parameter int ANGLE_WIDTH = 16,
    parameter int CORDIC_LAT  = 19
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [NUM_CH-1:0]             req_valid,
    output logic [NUM_CH-1:0]             req_ready,
    input  logic [NUM_CH*WIDTH-1:0]       req_x,
    input  logic [NUM_CH*WIDTH-1:0]       req_y,
    output logic [WIDTH-1:0]              cordic_x,
    output logic [WIDTH-1:0]              cordic_y,
    output logic                          cordic_valid_in,
    input  logic [ANGLE_WIDTH-1:0]        cordic_angle,
    input  logic                          cordic_valid_out,
    output logic [NUM_CH-1:0]             res_valid,
    output logic [NUM_CH*ANGLE_WIDTH-1:0] res_angle,
    output logic [$clog2(NUM_CH)-1:0]     res_chan,
    output logic                          busy,
    output logic                          sync_err
);

    localparam int ID_W  = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(CORDIC_LAT + 2);

    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  grant_id;
    logic [ID_W-1:0]  scan_id;
    logic             grant_found;
    logic             accept;
    logic [CNT_W-1:0] outstanding;

    // Stage 0 lines up with cordic_valid_in; stage CORDIC_LAT lines up with cordic_valid_out.
    logic             tag_v  [0:CORDIC_LAT];
    logic [ID_W-1:0]  tag_id [0:CORDIC_LAT];
    logic             exit_v;
    logic [ID_W-1:0]  exit_id;

    assign exit_v  = tag_v[CORDIC_LAT];
    assign exit_id = tag_id[CORDIC_LAT];

    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_id     = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            scan_id = ID_W'((int'(rr_ptr) + k) % NUM_CH);
            if (!grant_found && req_valid[scan_id]) begin
                grant_found = 1'b1;
                grant_id    = scan_id;
            end
        end
    end

    // Reset gates ready so nothing can be accepted while the core is being flushed.
    assign accept = enable & rst_n & grant_found;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign busy = (outstanding != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr          <= '0;
            cordic_x        <= '0;
            cordic_y        <= '0;
            cordic_valid_in <= 1'b0;
            outstanding     <= '0;
            for (int i = 0; i <= CORDIC_LAT; i++) begin
                tag_v[i]  <= 1'b0;
                tag_id[i] <= '0;
            end
        end else begin
            cordic_valid_in <= accept;
            if (accept) begin
                rr_ptr   <= (grant_id == ID_W'(NUM_CH - 1)) ? '0 : grant_id + ID_W'(1);
                cordic_x <= req_x[grant_id*WIDTH +: WIDTH];
                cordic_y <= req_y[grant_id*WIDTH +: WIDTH];
            end
            tag_v[0]  <= accept;
            tag_id[0] <= grant_id;
            for (int i = 1; i <= CORDIC_LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
            case ({accept, exit_v})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= '0;
            res_angle <= '0;
            res_chan  <= '0;
            sync_err  <= 1'b0;
        end else begin
            res_valid <= '0;
            if (exit_v != cordic_valid_out) begin
                sync_err <= 1'b1;
            end else if (exit_v) begin
                res_valid[exit_id]                          <= 1'b1;
                res_angle[exit_id*ANGLE_WIDTH +: ANGLE_WIDTH] <= cordic_angle;
                res_chan                                    <= exit_id;
            end
        end
    end

endmodule

// File: tb/tb_cordic_phase_arbiter.sv
// tb/tb_cordic_phase_arbiter.sv - directed self-checking bench for cordic_phase_arbiter
module tb_cordic_phase_arbiter;

    localparam int NUM_CH = 4;
    localparam int WIDTH  = 16;
    localparam int AW     = 16;
    localparam int LAT    = 19;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     enable;
    logic [NUM_CH-1:0]        req_valid;
    logic [NUM_CH-1:0]        req_ready;
    logic [NUM_CH*WIDTH-1:0]  req_x;
    logic [NUM_CH*WIDTH-1:0]  req_y;
    logic [WIDTH-1:0]         cordic_x;
    logic [WIDTH-1:0]         cordic_y;
    logic                     cordic_valid_in;
    logic [AW-1:0]            cordic_angle;
    logic                     cordic_valid_out;
    logic [NUM_CH-1:0]        res_valid;
    logic [NUM_CH*AW-1:0]     res_angle;
    logic [1:0]               res_chan;
    logic                     busy;
    logic                     sync_err;
    logic                     fault_force;

    int errors = 0;
    int checks = 0;
    int ready_seen;
    int res_cnt;
    int guard;

    cordic_phase_arbiter #(
        .NUM_CH(NUM_CH), .WIDTH(WIDTH), .ANGLE_WIDTH(AW), .CORDIC_LAT(LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
        .cordic_x(cordic_x), .cordic_y(cordic_y), .cordic_valid_in(cordic_valid_in),
        .cordic_angle(cordic_angle), .cordic_valid_out(cordic_valid_out),
        .res_valid(res_valid), .res_angle(res_angle), .res_chan(res_chan),
        .busy(busy), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    // Reference atan2 for the directed vectors used here, in 0.1 degree units.
    function automatic logic [AW-1:0] ref_atan(input logic signed [WIDTH-1:0] x,
                                               input logic signed [WIDTH-1:0] y);
        if (x > 0 && y == x)       return 16'd450;
        else if (x > 0 && y == 0)  return 16'd0;
        else if (x < 0 && y == 0)  return 16'd1800;
        else if (x == 0 && y > 0)  return 16'd900;
        else if (x == 0 && y < 0)  return -16'sd900;
        else                       return 16'h7fff;
    endfunction

    logic          mv [LAT];
    logic [AW-1:0] ma [LAT];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                mv[i] <= 1'b0;
                ma[i] <= '0;
            end
        end else begin
            mv[0] <= cordic_valid_in;
            ma[0] <= ref_atan(cordic_x, cordic_y);
            for (int i = 1; i < LAT; i++) begin
                mv[i] <= mv[i-1];
                ma[i] <= ma[i-1];
            end
        end
    end

    assign cordic_valid_out = mv[LAT-1] | fault_force;
    assign cordic_angle     = ma[LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input int x, input int y);
        req_x[ch*WIDTH +: WIDTH] = WIDTH'(x);
        req_y[ch*WIDTH +: WIDTH] = WIDTH'(y);
    endtask

    function automatic logic [AW-1:0] ang(input int ch);
        return res_angle[ch*AW +: AW];
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; req_valid = '0; req_x = '0; req_y = '0; fault_force = 1'b0;
        step(3);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_cvalid", 32'(cordic_valid_in), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_res_angle", 32'(res_angle), 0);
        chk("rst_sync_err", 32'(sync_err), 0);
        rst_n = 1'b1;
        step(1);

        // Single request on channel 2.
        enable = 1'b1;
        set_ch(2, 1000, 1000);
        req_valid = 4'b0100;
        #1;
        chk("t1_ready", 32'(req_ready), 4'b0100);
        step(1);
        req_valid = '0;
        chk("t1_cvalid", 32'(cordic_valid_in), 1);
        chk("t1_cx", 32'(cordic_x), 1000);
        chk("t1_cy", 32'(cordic_y), 1000);
        chk("t1_busy", 32'(busy), 1);
        step(1);
        chk("t1_cvalid_off", 32'(cordic_valid_in), 0);
        chk("t1_cx_hold", 32'(cordic_x), 1000);
        step(18);
        chk("t1_res_early", 32'(res_valid), 0);
        step(1);
        chk("t1_res_valid", 32'(res_valid), 4'b0100);
        chk("t1_res_angle", 32'(ang(2)), 450);
        chk("t1_res_chan", 32'(res_chan), 2);
        chk("t1_other_ang", 32'(ang(0)), 0);
        chk("t1_busy_end", 32'(busy), 0);
        step(1);
        chk("t1_res_pulse", 32'(res_valid), 0);

        // Four channels valid right after reset.
        do_reset();
        set_ch(0, 1000, 0);
        set_ch(1, 0, 1000);
        set_ch(2, 1000, 1000);
        set_ch(3, -1000, 0);
        req_valid = 4'b1111;
        #1;
        chk("t2_g0", 32'(req_ready), 4'b0001);
        step(1); req_valid = 4'b1110; #1;
        chk("t2_g1", 32'(req_ready), 4'b0010);
        step(1); req_valid = 4'b1100; #1;
        chk("t2_g2", 32'(req_ready), 4'b0100);
        step(1); req_valid = 4'b1000; #1;
        chk("t2_g3", 32'(req_ready), 4'b1000);
        step(1); req_valid = '0;
        step(17);
        chk("t2_r0", 32'(res_valid), 4'b0001);
        chk("t2_a0", 32'(ang(0)), 0);
        step(1);
        chk("t2_r1", 32'(res_valid), 4'b0010);
        chk("t2_a1", 32'(ang(1)), 900);
        step(1);
        chk("t2_r2", 32'(res_valid), 4'b0100);
        chk("t2_a2", 32'(ang(2)), 450);
        step(1);
        chk("t2_r3", 32'(res_valid), 4'b1000);
        chk("t2_a3", 32'(ang(3)), 1800);
        chk("t2_chan3", 32'(res_chan), 3);
        chk("t2_a1_hold", 32'(ang(1)), 900);
        chk("t2_busy", 32'(busy), 0);

        // Fairness between ch0 and ch3 with the pointer at 1.
        req_valid = 4'b0001;
        #1;
        chk("t3_pre", 32'(req_ready), 4'b0001);
        step(1);
        req_valid = 4'b1001;
        #1;
        chk("t3_f0", 32'(req_ready), 4'b1000);
        step(1);
        chk("t3_f1", 32'(req_ready), 4'b0001);
        step(1);
        chk("t3_f2", 32'(req_ready), 4'b1000);
        step(1);
        chk("t3_f3", 32'(req_ready), 4'b0001);
        step(1);
        req_valid = '0;
        res_cnt = 0;
        guard = 0;
        while (busy && guard < 40) begin
            step(1);
            res_cnt += $countones(res_valid);
            guard++;
        end
        chk("t3_drain_busy", 32'(busy), 0);
        chk("t3_res_count", 32'(res_cnt), 5);

        // enable dropped three cycles into a burst; pointer now at 1.
        req_valid = 4'b1111;
        #1;
        chk("t4_g1", 32'(req_ready), 4'b0010);
        step(1); req_valid = 4'b1101; #1;
        chk("t4_g2", 32'(req_ready), 4'b0100);
        step(1); req_valid = 4'b1001; #1;
        chk("t4_g3", 32'(req_ready), 4'b1000);
        step(1); req_valid = 4'b0001; enable = 1'b0; #1;
        chk("t4_blocked", 32'(req_ready), 0);
        ready_seen = 0;
        res_cnt = 0;
        for (int c = 4; c <= 22; c++) begin
            step(1);
            if (req_ready != '0) ready_seen++;
            res_cnt += $countones(res_valid);
        end
        chk("t4_busy_22", 32'(busy), 1);
        chk("t4_res_22", 32'(res_valid), 4'b0100);
        step(1);
        chk("t4_res_23", 32'(res_valid), 4'b1000);
        chk("t4_busy_23", 32'(busy), 0);
        res_cnt += $countones(res_valid);
        for (int c = 0; c < 10; c++) begin
            step(1);
            if (req_ready != '0) ready_seen++;
            res_cnt += $countones(res_valid);
        end
        chk("t4_no_ready", 32'(ready_seen), 0);
        chk("t4_res_total", 32'(res_cnt), 3);
        req_valid = '0;
        enable = 1'b1;

        // Result strobe with nothing in flight.
        fault_force = 1'b1;
        step(1);
        fault_force = 1'b0;
        chk("t5_sync_err", 32'(sync_err), 1);
        chk("t5_no_res", 32'(res_valid), 0);
        step(3);
        chk("t5_sticky", 32'(sync_err), 1);
        chk("t5_busy", 32'(busy), 0);

        // Reset with five requests in flight.
        do_reset();
        chk("t6_err_clr", 32'(sync_err), 0);
        req_valid = 4'b1111;
        step(5);
        req_valid = '0;
        step(5);
        chk("t6_busy_pre", 32'(busy), 1);
        req_valid = 4'b1111;
        rst_n = 1'b0;
        #1;
        chk("t6_ready", 32'(req_ready), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_cx", 32'(cordic_x), 0);
        chk("t6_cvalid", 32'(cordic_valid_in), 0);
        chk("t6_res_valid", 32'(res_valid), 0);
        req_valid = '0;
        step(2);
        rst_n = 1'b1;
        res_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            step(1);
            res_cnt += $countones(res_valid);
        end
        chk("t6_no_stale", 32'(res_cnt), 0);
        chk("t6_busy_after", 32'(busy), 0);
        chk("t6_sync_ok", 32'(sync_err), 0);
        req_valid = 4'b1001;
        #1;
        chk("t6_rr_restart", 32'(req_ready), 4'b0001);
        step(1);
        req_valid = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
